// File: rtl/hist_readout_ctrl.sv
// Frame-end readout sequencer for the ping-pong histogram collector: reads the idle bank,
// streams a saturating cumulative sum (CDF), then triggers the collector's bank clear.
module hist_readout_ctrl #(
  parameter int BITWIDTH = 16,
  parameter int CDFW     = 24,
  parameter int SETTLE   = 2,
  parameter int RD_LAT   = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic                video_eop,
  input  logic [BITWIDTH-1:0] hist_q,
  output logic                data_load,
  output logic [7:0]          data_load_addr,
  output logic                clean,
  output logic                cdf_valid,
  output logic [7:0]          cdf_addr,
  output logic [CDFW-1:0]     cdf_data,
  output logic                busy,
  output logic                done,
  output logic                overrun
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_READ,
    S_DRAIN,
    S_CLEAN,
    S_CLEAN_WAIT
  } state_t;

  localparam int CNT_W = 9;
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST  = CNT_W'(RD_LAT);
  localparam logic [CNT_W-1:0] WAIT_LAST   = CNT_W'(256);

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [7:0]           addr_q, addr_d;
  logic [CDFW-1:0]      acc_q, acc_d;
  logic                 ld_vld_q [RD_LAT];
  logic                 ld_vld_d [RD_LAT];
  logic [7:0]           ld_addr_q [RD_LAT];
  logic [7:0]           ld_addr_d [RD_LAT];
  logic                 cdf_valid_q, cdf_valid_d;
  logic [7:0]           cdf_addr_q, cdf_addr_d;
  logic [CDFW-1:0]      cdf_data_q, cdf_data_d;
  logic                 overrun_q, overrun_d;

  // One extra bit catches the carry; on carry the sum pins at all-ones instead of wrapping.
  logic [CDFW:0]        sum;
  logic [CDFW-1:0]      sat_sum;

  assign sum     = {1'b0, acc_q} + (CDFW + 1)'(hist_q);
  assign sat_sum = sum[CDFW] ? '1 : sum[CDFW-1:0];

  always_comb begin
    // NOTE: every *_d is given its hold value first, so no branch can infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    acc_d     = acc_q;
    overrun_d = video_eop && (state_q != S_IDLE);

    case (state_q)
      S_IDLE: begin
        if (video_eop && enable) begin
          state_d = S_SETTLE;
          cnt_d   = '0;
          acc_d   = '0;
        end
      end
      S_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          state_d = S_READ;
          cnt_d   = '0;
          addr_d  = '0;
        end else begin
          cnt_d = cnt_q + 9'd1;
        end
      end
      S_READ: begin
        if (addr_q == 8'd255) begin
          state_d = S_DRAIN;
          cnt_d   = '0;
        end else begin
          addr_d = addr_q + 8'd1;
        end
      end
      S_DRAIN: begin
        if (cnt_q == DRAIN_LAST) begin
          state_d = S_CLEAN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 9'd1;
        end
      end
      S_CLEAN: begin
        state_d = S_CLEAN_WAIT;
        cnt_d   = '0;
      end
      S_CLEAN_WAIT: begin
        if (cnt_q == WAIT_LAST) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 9'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Read-latency shadow of data_load/addr; its tail marks the cycle hist_q is valid.
    ld_vld_d[0]  = (state_q == S_READ);
    ld_addr_d[0] = addr_q;
    for (int i = 1; i < RD_LAT; i++) begin
      ld_vld_d[i]  = ld_vld_q[i-1];
      ld_addr_d[i] = ld_addr_q[i-1];
    end

    cdf_valid_d = 1'b0;
    cdf_addr_d  = cdf_addr_q;
    cdf_data_d  = cdf_data_q;
    if (ld_vld_q[RD_LAT-1]) begin
      cdf_valid_d = 1'b1;
      cdf_addr_d  = ld_addr_q[RD_LAT-1];
      cdf_data_d  = sat_sum;
      acc_d       = sat_sum;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      acc_q       <= '0;
      cdf_valid_q <= 1'b0;
      cdf_addr_q  <= '0;
      cdf_data_q  <= '0;
      overrun_q   <= 1'b0;
      // NOTE: the latency shadow is reset too, so an aborted read cannot leak a cdf_valid.
      for (int i = 0; i < RD_LAT; i++) begin
        ld_vld_q[i]  <= 1'b0;
        ld_addr_q[i] <= '0;
      end
    end else begin
      // NOTE: non-blocking updates keep every register sampling pre-edge values.
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      acc_q       <= acc_d;
      cdf_valid_q <= cdf_valid_d;
      cdf_addr_q  <= cdf_addr_d;
      cdf_data_q  <= cdf_data_d;
      overrun_q   <= overrun_d;
      for (int i = 0; i < RD_LAT; i++) begin
        ld_vld_q[i]  <= ld_vld_d[i];
        ld_addr_q[i] <= ld_addr_d[i];
      end
    end
  end

  assign data_load      = (state_q == S_READ);
  assign data_load_addr = addr_q;
  assign clean          = (state_q == S_CLEAN);
  assign busy           = (state_q != S_IDLE);
  assign done           = (state_q == S_CLEAN_WAIT) && (cnt_q == WAIT_LAST);
  assign cdf_valid      = cdf_valid_q;
  assign cdf_addr       = cdf_addr_q;
  assign cdf_data       = cdf_data_q;
  assign overrun        = overrun_q;

endmodule
